// File: rtl/bcd_display_scan.sv
// Time-multiplexed six-digit 7-segment driver for an HH:MM:SS clock.
// Takes one snapshot of the digits per scan frame, scans one digit per slot and blinks the separator points.
module bcd_display_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter bit          COMMON_ANODE = 1'b1,
    parameter bit          LZ_BLANK     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] segundoDer,
    input  logic [3:0] segundoIzq,
    input  logic [3:0] minutosDer,
    input  logic [3:0] minutosIzq,
    input  logic [3:0] horasDiDer,
    input  logic [1:0] horasDiIzq,
    output logic [5:0] anodo,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned NDIG  = 6;
    localparam int unsigned DW    = 4;
    localparam int unsigned SEGW  = 7;
    localparam int unsigned IW    = 3;

    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_OFF    = {NDIG{COMMON_ANODE}};
    localparam logic [SEGW-1:0] SEG_OFF   = {SEGW{COMMON_ANODE}};

    logic [PW-1:0]            presc_q, presc_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [NDIG-1:0][DW-1:0]  shadow_q, shadow_d;
    logic                     load_pend_q, load_pend_d;
    logic [NDIG-1:0]          anodo_q, anodo_d;
    logic [SEGW-1:0]          seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic                     frame_tick_q, frame_tick_d;

    logic                     tick_c, wrap_c, load_now_c;
    logic [NDIG-1:0][DW-1:0]  live_c, view_c;
    logic [DW-1:0]            digit_c;
    logic [NDIG-1:0]          an_hi_c;
    logic [SEGW-1:0]          seg_hi_c;
    logic                     dp_hi_c;

    // Active-high {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [SEGW-1:0] bcd_to_seg(input logic [DW-1:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;
        endcase
    endfunction

    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        load_pend_d  = load_pend_q;
        digit_c      = '0;
        an_hi_c      = '0;
        seg_hi_c     = '0;
        dp_hi_c      = 1'b0;

        live_c     = {{2'b00, horasDiIzq}, horasDiDer, minutosIzq,
                      minutosDer, segundoIzq, segundoDer};
        tick_c     = en && (presc_q == PRESC_MAX);
        wrap_c     = tick_c && (idx_q == IDX_LAST);
        load_now_c = en && load_pend_q;

        if (en) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
        end
        if (tick_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (load_now_c) begin
            load_pend_d = 1'b0;
        end
        if (wrap_c || load_now_c) begin
            shadow_d = live_c;
        end

        // The very first lit slot shows the digits being captured, not the reset zeros.
        view_c = load_now_c ? live_c : shadow_q;

        case (idx_q)
            3'd0:    digit_c = view_c[0];
            3'd1:    digit_c = view_c[1];
            3'd2:    digit_c = view_c[2];
            3'd3:    digit_c = view_c[3];
            3'd4:    digit_c = view_c[4];
            3'd5:    digit_c = view_c[5];
            default: digit_c = '0;
        endcase

        if (en) begin
            an_hi_c  = NDIG'(1) << idx_q;
            seg_hi_c = bcd_to_seg(digit_c);
            if (LZ_BLANK && (idx_q == IDX_LAST) && (digit_c == '0)) begin
                seg_hi_c = '0;
            end
            dp_hi_c = ((idx_q == 3'd2) || (idx_q == 3'd4)) && !view_c[0][0];
        end

        anodo_d      = an_hi_c ^ AN_OFF;
        seg_d        = seg_hi_c ^ SEG_OFF;
        dp_d         = dp_hi_c ^ COMMON_ANODE;
        frame_tick_d = wrap_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            load_pend_q  <= 1'b1;
            anodo_q      <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= COMMON_ANODE;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            load_pend_q  <= load_pend_d;
            anodo_q      <= anodo_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anodo      = anodo_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (SCAN_DIV=4, common anode), with a second
// instance using leading-zero blanking driven from the same inputs.
module tb_bcd_display_scan;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [6:0] seg_lz;
    } exp_t;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] segundoDer, segundoIzq, minutosDer, minutosIzq, horasDiDer;
    logic [1:0] horasDiIzq;
    logic [5:0] anodo, anodo_lz;
    logic [6:0] seg, seg_lz;
    logic       dp, dp_lz, frame_tick, frame_tick_lz;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ft_count = 0;
    exp_t sb_q[$];
    logic [3:0] fr [0:5][0:5];

    always #5 clk = ~clk;

    bcd_display_scan #(.SCAN_DIV(4), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .segundoDer(segundoDer), .segundoIzq(segundoIzq),
        .minutosDer(minutosDer), .minutosIzq(minutosIzq),
        .horasDiDer(horasDiDer), .horasDiIzq(horasDiIzq),
        .anodo(anodo), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    bcd_display_scan #(.SCAN_DIV(4), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .en(en),
        .segundoDer(segundoDer), .segundoIzq(segundoIzq),
        .minutosDer(minutosDer), .minutosIzq(minutosIzq),
        .horasDiDer(horasDiDer), .horasDiIzq(horasDiIzq),
        .anodo(anodo_lz), .seg(seg_lz), .dp(dp_lz), .frame_tick(frame_tick_lz)
    );

    always @(negedge clk) begin
        if (rst_n && frame_tick) ft_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int f, input logic [3:0] h1, input logic [3:0] h0,
                             input logic [3:0] m1, input logic [3:0] m0,
                             input logic [3:0] s1, input logic [3:0] s0);
        fr[f][5] = h1; fr[f][4] = h0; fr[f][3] = m1;
        fr[f][2] = m0; fr[f][1] = s1; fr[f][0] = s0;
    endtask

    task automatic apply_inputs(input int f);
        logic [3:0] h1;
        h1 = fr[f][5];
        segundoDer = fr[f][0];
        segundoIzq = fr[f][1];
        minutosDer = fr[f][2];
        minutosIzq = fr[f][3];
        horasDiDer = fr[f][4];
        horasDiIzq = h1[1:0];
    endtask

    function automatic exp_t exp_slot(input int f, input int k);
        exp_t       e;
        logic [3:0] d;
        logic [3:0] s0;
        d  = fr[f][k];
        s0 = fr[f][0];
        e.an     = ~(6'(1) << k);
        e.seg    = ~SEG_TAB[d];
        e.dp     = ~(((k == 2) || (k == 4)) && (s0[0] == 1'b0));
        e.seg_lz = ((k == 5) && (d == 4'd0)) ? 7'h7F : ~SEG_TAB[d];
        return e;
    endfunction

    task automatic push_frame(input int f);
        for (int k = 0; k < 6; k++) sb_q.push_back(exp_slot(f, k));
    endtask

    task automatic compare_slot(input string tag, input exp_t e);
        check({tag, " anodo"},    32'(anodo),    32'(e.an));
        check({tag, " seg"},      32'(seg),      32'(e.seg));
        check({tag, " dp"},       32'(dp),       32'(e.dp));
        check({tag, " anodo_lz"}, 32'(anodo_lz), 32'(e.an));
        check({tag, " seg_lz"},   32'(seg_lz),   32'(e.seg_lz));
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            compare_slot(tag, e);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, " anodo"},      32'(anodo),      32'h3F);
        check({tag, " seg"},        32'(seg),        32'h7F);
        check({tag, " dp"},         32'(dp),         32'd1);
        check({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        set_frame(0, 4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        set_frame(1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        set_frame(2, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'hB);
        set_frame(3, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
        set_frame(4, 4'd1, 4'd9, 4'd4, 4'd8, 4'd2, 4'd6);
        set_frame(5, 4'd0, 4'd7, 4'd1, 4'd5, 4'd3, 4'd1);

        rst_n = 1'b0;
        en    = 1'b0;
        apply_inputs(0);
        repeat (2) @(negedge clk);
        check_dark("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_dark("idle_en0");

        // Sample each slot mid-way; inputs for the next frame change after slot 2.
        en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            push_frame(f);
            for (int k = 0; k < 6; k++) begin
                if (f == 5 && k == 4) break;
                repeat ((f == 0 && k == 0) ? 2 : 4) @(negedge clk);
                if (k == 0) check($sformatf("f%0d frame_tick_count", f), 32'(ft_count), 32'(f));
                pop_and_compare($sformatf("f%0d s%0d", f, k));
                if (k == 2 && f < 5) apply_inputs(f + 1);
            end
        end

        // Pause in slot 3 of frame 5, then resume from the held prescaler/index.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_dark($sformatf("pause c%0d", i));
        end
        check("pause frame_tick_count", 32'(ft_count), 32'd5);
        en = 1'b1;
        @(negedge clk);
        compare_slot("resume s3", exp_slot(5, 3));
        repeat (2) @(negedge clk);
        pop_and_compare("resume s4");
        repeat (4) @(negedge clk);
        pop_and_compare("resume s5");
        repeat (4) @(negedge clk);
        check("resume frame_tick_count", 32'(ft_count), 32'd6);
        compare_slot("f6 s0", exp_slot(5, 0));

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midslot_reset anodo", 32'(anodo), 32'h3F);
        check("midslot_reset seg",   32'(seg),   32'h7F);
        check("midslot_reset dp",    32'(dp),    32'd1);
        check("midslot_reset ft",    32'(frame_tick), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
